// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 5-stage MIPS hazard logic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DEF_REG_AW     = 5;
    localparam int DEF_DIV_CYCLES = 34;

    // Dominant reason the front of the pipeline is held this cycle.
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_MEM  = 3'd1,
        CAUSE_DIV  = 3'd2,
        CAUSE_LW   = 3'd3,
        CAUSE_BR   = 3'd4
    } stall_cause_e;

    function automatic stall_cause_e dominant_cause(input logic mem, input logic div,
                                                    input logic lw,  input logic br);
        if (mem)      return CAUSE_MEM;
        else if (div) return CAUSE_DIV;
        else if (lw)  return CAUSE_LW;
        else if (br)  return CAUSE_BR;
        else          return CAUSE_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_busy_cnt.sv
// ============================================================================
//  Module      : div_busy_cnt
//  Description : E-stage occupancy counter for multi-cycle div/divu.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_busy_cnt
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic div_start_i,
    input  logic mem_stall_i,
    input  logic clear_i,
    output logic div_busy_o,
    output logic div_stall_o
);

    localparam int             CW   = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0]  LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          idle;
    logic          start;

    always_comb begin
        idle  = (cnt_q == '0);
        start = idle & div_start_i & ~clear_i;
        cnt_d = cnt_q;
        // A flush kills the divide outright; a bus stall only freezes it.
        if (clear_i)
            cnt_d = '0;
        else if (start)
            cnt_d = LOAD;
        else if (!idle && !mem_stall_i)
            cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // E is released in the last busy cycle (counter == 1).
    assign div_busy_o  = ~idle | start;
    assign div_stall_o = (div_start_i & (cnt_q != ONE)) | (cnt_q > ONE);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush/forward controller for the F/D/E/M/W pipeline.
//                Optional HAZARD_PERF_EN adds stall-cause counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int FWD_W2D    = 1
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              regjumpD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              div_startE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              flush_exceptionM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              i_stall,
    input  logic              d_stall,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lw,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_div,
    output logic [PERF_W-1:0] perf_mem
`endif
);

    function automatic logic hit(input logic [REG_AW-1:0] dst, input logic we,
                                 input logic [REG_AW-1:0] src);
        return we && (src != '0) && (dst == src);
    endfunction

    logic       w2d_en;
    logic       mem_stall;
    logic       flush_pend_q;
    logic       flush_pend_d;
    logic       flush_req;
    logic       lwstall;
    logic       brstall;
    logic       jrstall;
    logic       hazard_stall;
    logic       dep_rs;
    logic       dep_rt;
    logic       div_stall;
    logic       div_busy_c;
    logic [1:0] fa_d;
    logic [1:0] fb_d;
    logic [1:0] fa_e;
    logic [1:0] fb_e;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_mw;
    logic       flush_dmw;
    logic       flush_e;

    if (FWD_W2D != 0) begin : g_w2d
        assign w2d_en = 1'b1;
    end else begin : g_no_w2d
        assign w2d_en = 1'b0;
    end

    always_comb begin
        fa_e = FWD_RF;
        fb_e = FWD_RF;
        fa_d = FWD_RF;
        fb_d = FWD_RF;
        if (hit(writeregM, regwriteM, rsE))      fa_e = FWD_M;
        else if (hit(writeregW, regwriteW, rsE)) fa_e = FWD_W;
        if (hit(writeregM, regwriteM, rtE))      fb_e = FWD_M;
        else if (hit(writeregW, regwriteW, rtE)) fb_e = FWD_W;
        if (hit(writeregM, regwriteM, rsD))                fa_d = FWD_M;
        else if (w2d_en && hit(writeregW, regwriteW, rsD)) fa_d = FWD_W;
        if (hit(writeregM, regwriteM, rtD))                fb_d = FWD_M;
        else if (w2d_en && hit(writeregW, regwriteW, rtD)) fb_d = FWD_W;
    end

    // Without W->D forwarding the compare must wait for the regfile write.
    assign dep_rs = hit(writeregE, regwriteE, rsD) | hit(writeregM, memtoregM, rsD) |
                    (~w2d_en & hit(writeregW, regwriteW, rsD));
    assign dep_rt = hit(writeregE, regwriteE, rtD) | hit(writeregM, memtoregM, rtD) |
                    (~w2d_en & hit(writeregW, regwriteW, rtD));

    assign lwstall      = memtoregE & (hit(rtE, 1'b1, rsD) | hit(rtE, 1'b1, rtD));
    assign brstall      = branchD & (dep_rs | dep_rt);
    assign jrstall      = regjumpD & dep_rs;
    assign hazard_stall = lwstall | brstall | jrstall;

    assign mem_stall = i_stall | d_stall;
    assign flush_req = flush_exceptionM | flush_pend_q;

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (mem_stall && flush_exceptionM)
            flush_pend_d = 1'b1;
        else if (!mem_stall)
            flush_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            flush_pend_q <= 1'b0;
        else
            flush_pend_q <= flush_pend_d;
    end

    div_busy_cnt #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_busy_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .div_start_i (div_startE),
        .mem_stall_i (mem_stall),
        .clear_i     (flush_req),
        .div_busy_o  (div_busy_c),
        .div_stall_o (div_stall)
    );

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_mw  = 1'b0;
        flush_dmw = 1'b0;
        flush_e   = 1'b0;
        if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_mw = 1'b1;
        end else begin
            stall_d   = hazard_stall | div_stall;
            stall_e   = div_stall;
            stall_f   = stall_d & ~flush_req;
            flush_dmw = flush_req;
            // Bubble into E only when E itself advances.
            flush_e   = flush_req | (hazard_stall & ~div_stall);
        end
    end

    // Everything reads inactive while reset is asserted.
    assign forwardaD = resetn ? fa_d : FWD_RF;
    assign forwardbD = resetn ? fb_d : FWD_RF;
    assign forwardaE = resetn ? fa_e : FWD_RF;
    assign forwardbE = resetn ? fb_e : FWD_RF;
    assign stallF    = resetn & stall_f;
    assign stallD    = resetn & stall_d;
    assign stallE    = resetn & stall_e;
    assign stallM    = resetn & stall_mw;
    assign stallW    = resetn & stall_mw;
    assign flushD    = resetn & flush_dmw;
    assign flushE    = resetn & flush_e;
    assign flushM    = resetn & flush_dmw;
    assign flushW    = resetn & flush_dmw;
    assign div_busy  = resetn & div_busy_c;

`ifdef HAZARD_PERF_EN
    stall_cause_e      cause;
    logic [3:0]        perf_inc;
    logic [PERF_W-1:0] perf_q [4];

    always_comb begin
        cause    = dominant_cause(mem_stall, div_stall, lwstall, brstall | jrstall);
        perf_inc = 4'b0000;
        case (cause)
            CAUSE_LW:  perf_inc[0] = 1'b1;
            CAUSE_BR:  perf_inc[1] = 1'b1;
            CAUSE_DIV: perf_inc[2] = 1'b1;
            CAUSE_MEM: perf_inc[3] = 1'b1;
            default:   perf_inc    = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) perf_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (perf_inc[k] && (perf_q[k] != '1))
                    perf_q[k] <= perf_q[k] + PERF_W'(1);
        end
    end

    assign perf_lw  = perf_q[0];
    assign perf_br  = perf_q[1];
    assign perf_div = perf_q[2];
    assign perf_mem = perf_q[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (two configurations).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int DC_A = 34;
    localparam int DC_B = 2;

    typedef struct packed {
        logic [1:0] faD, fbD, faE, fbE;
        logic sF, sD, sE, sM, sW, fD, fE, fM, fW, busy;
    } outs_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regjumpD, regwriteE, memtoregE, div_startE;
    logic regwriteM, memtoregM, flush_exceptionM, regwriteW, i_stall, d_stall;

    logic [1:0] faD_a, fbD_a, faE_a, fbE_a, faD_b, fbD_b, faE_b, fbE_b;
    logic sF_a, sD_a, sE_a, sM_a, sW_a, fD_a, fE_a, fM_a, fW_a, busy_a;
    logic sF_b, sD_b, sE_b, sM_b, sW_b, fD_b, fE_b, fM_b, fW_b, busy_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] plw_a, pbr_a, pdv_a, pmm_a, plw_b, pbr_b, pdv_b, pmm_b;
`endif

    hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(DC_A), .FWD_W2D(1)) dut_a (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .regjumpD(regjumpD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .flush_exceptionM(flush_exceptionM), .writeregW(writeregW),
        .regwriteW(regwriteW), .i_stall(i_stall), .d_stall(d_stall),
        .forwardaD(faD_a), .forwardbD(fbD_a), .forwardaE(faE_a), .forwardbE(fbE_a),
        .stallF(sF_a), .stallD(sD_a), .stallE(sE_a), .stallM(sM_a), .stallW(sW_a),
        .flushD(fD_a), .flushE(fE_a), .flushM(fM_a), .flushW(fW_a),
        .div_busy(busy_a)
`ifdef HAZARD_PERF_EN
        , .perf_lw(plw_a), .perf_br(pbr_a), .perf_div(pdv_a), .perf_mem(pmm_a)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(DC_B), .FWD_W2D(0)) dut_b (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .regjumpD(regjumpD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .flush_exceptionM(flush_exceptionM), .writeregW(writeregW),
        .regwriteW(regwriteW), .i_stall(i_stall), .d_stall(d_stall),
        .forwardaD(faD_b), .forwardbD(fbD_b), .forwardaE(faE_b), .forwardbE(fbE_b),
        .stallF(sF_b), .stallD(sD_b), .stallE(sE_b), .stallM(sM_b), .stallW(sW_b),
        .flushD(fD_b), .flushE(fE_b), .flushM(fM_b), .flushW(fW_b),
        .div_busy(busy_b)
`ifdef HAZARD_PERF_EN
        , .perf_lw(plw_b), .perf_br(pbr_b), .perf_div(pdv_b), .perf_mem(pmm_b)
`endif
    );

    outs_t oa, ob;
    assign oa = {faD_a, fbD_a, faE_a, fbE_a, sF_a, sD_a, sE_a, sM_a, sW_a,
                 fD_a, fE_a, fM_a, fW_a, busy_a};
    assign ob = {faD_b, fbD_b, faE_b, fbE_b, sF_b, sD_b, sE_b, sM_b, sW_b,
                 fD_b, fE_b, fM_b, fW_b, busy_b};

    int checks   = 0;
    int failures = 0;

    // Reference model state: divide in progress, busy cycles already served,
    // and an exception waiting for the bus stall to end.
    bit act  [2];
    int el   [2];
    bit pend [2];

    function automatic int dcyc(input int i);
        return (i == 0) ? DC_A : DC_B;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                act[i]  <= 1'b0;
                el[i]   <= 0;
                pend[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flush_exceptionM || pend[i]) begin
                    act[i] <= 1'b0;
                end else if (!act[i]) begin
                    if (div_startE) begin
                        act[i] <= 1'b1;
                        el[i]  <= 1;
                    end
                end else if (!(i_stall || d_stall)) begin
                    el[i]  <= el[i] + 1;
                    act[i] <= (el[i] + 1 < dcyc(i));
                end
                if ((i_stall || d_stall) && flush_exceptionM) pend[i] <= 1'b1;
                else if (!(i_stall || d_stall))               pend[i] <= 1'b0;
            end
        end
    end

    function automatic bit hit(input logic [4:0] dst, input logic we, input logic [4:0] src);
        return we && (src != 5'd0) && (dst == src);
    endfunction

    function automatic bit dep(input int i, input logic [4:0] r);
        return hit(writeregE, regwriteE, r) || hit(writeregM, memtoregM, r) ||
               ((i == 1) && hit(writeregW, regwriteW, r));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r, input bit allow_w);
        if (hit(writeregM, regwriteM, r))             return 2'b10;
        if (allow_w && hit(writeregW, regwriteW, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic outs_t model(input int i);
        outs_t e;
        bit lw, br, jr, haz, mem, freq, divst;
        e     = '0;
        e.faE = fsel(rsE, 1'b1);
        e.fbE = fsel(rtE, 1'b1);
        e.faD = fsel(rsD, i == 0);
        e.fbD = fsel(rtD, i == 0);
        lw    = memtoregE && (hit(rtE, 1'b1, rsD) || hit(rtE, 1'b1, rtD));
        br    = branchD && (dep(i, rsD) || dep(i, rtD));
        jr    = regjumpD && dep(i, rsD);
        haz   = lw || br || jr;
        mem   = i_stall || d_stall;
        freq  = flush_exceptionM || pend[i];
        divst = act[i] ? (el[i] < dcyc(i) - 1) : div_startE;
        e.busy = act[i] || (div_startE && !freq);
        if (mem) begin
            {e.sF, e.sD, e.sE, e.sM, e.sW} = 5'b11111;
        end else begin
            e.sD = haz || divst;
            e.sE = divst;
            e.sF = e.sD && !freq;
            e.fD = freq;
            e.fM = freq;
            e.fW = freq;
            e.fE = freq || (haz && !divst);
        end
        return e;
    endfunction

    task automatic idle_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, regjumpD, regwriteE, memtoregE, div_startE} = '0;
        {regwriteM, memtoregM, flush_exceptionM, regwriteW, i_stall, d_stall} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        branchD = 1; rsD = 5'd3; memtoregE = 1; rtE = 5'd3; div_startE = 1;
        regwriteM = 1; writeregM = 5'd3; rsE = 5'd3; i_stall = 1; flush_exceptionM = 1;
        #1;
        checks++;
        if (oa !== '0) begin failures++; $display("FAIL reset_a: got %h want 0", oa); end
        checks++;
        if (ob !== '0) begin failures++; $display("FAIL reset_b: got %h want 0", ob); end
        tick();
        idle_inputs();
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (oa !== '0 || ob !== '0) begin
            failures++; $display("FAIL post_reset: got %h/%h want 0", oa, ob);
        end
        tick();
    endtask

    task automatic test_lw_hazard();
        do_reset();
        memtoregE = 1; regwriteE = 1; rtE = 5'd3; writeregE = 5'd3; rsD = 5'd3; rtD = 5'd4;
        @(negedge clk);
        checks++;
        if ({sF_a, sD_a, fE_a, sE_a} !== 4'b1110) begin
            failures++; $display("FAIL lw_stall: got %b want 1110", {sF_a, sD_a, fE_a, sE_a});
        end
        tick();
        idle_inputs();
        rsE = 5'd3; rtE = 5'd4; regwriteW = 1; writeregW = 5'd3; rsD = 5'd7; rtD = 5'd8;
        @(negedge clk);
        checks++;
        if ({faE_a, fbE_a, sD_a} !== 5'b01000) begin
            failures++; $display("FAIL lw_fwd_w: got %b want 01000", {faE_a, fbE_a, sD_a});
        end
        regwriteM = 1; writeregM = 5'd3;
        @(negedge clk);
        checks++;
        if (faE_a !== 2'b10) begin failures++; $display("FAIL fwd_m_prio: got %b want 10", faE_a); end
        tick();
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        memtoregE = 1; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        @(negedge clk);
        checks++;
        if ({faE_a, sD_a, fE_a} !== 4'b0000) begin
            failures++; $display("FAIL reg0: got %b want 0000", {faE_a, sD_a, fE_a});
        end
        tick();
    endtask

    task automatic test_div();
        int nb, nsd, nse, nfe;
        nb = 0; nsd = 0; nse = 0; nfe = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            div_startE = (c < 34);
            @(negedge clk);
            nb  += int'(busy_a);
            nsd += int'(sD_a);
            nse += int'(sE_a);
            nfe += int'(fE_a);
            tick();
        end
        checks++;
        if (nb != 34)  begin failures++; $display("FAIL div_busy_cycles: got %0d want 34", nb); end
        checks++;
        if (nsd != 33) begin failures++; $display("FAIL div_stallD_cycles: got %0d want 33", nsd); end
        checks++;
        if (nse != 33) begin failures++; $display("FAIL div_stallE_cycles: got %0d want 33", nse); end
        checks++;
        if (nfe != 0)  begin failures++; $display("FAIL div_flushE_cycles: got %0d want 0", nfe); end
    endtask

    task automatic test_div_memstall();
        int nb, nall, nse;
        nb = 0; nall = 0; nse = 0;
        do_reset();
        for (int c = 0; c < 45; c++) begin
            div_startE = (c < 39);
            d_stall    = (c >= 5 && c < 10);
            @(negedge clk);
            nb  += int'(busy_a);
            nse += int'(sE_a);
            if ({sF_a, sD_a, sE_a, sM_a, sW_a, fD_a, fE_a, fM_a, fW_a} == 9'b111110000) nall++;
            tick();
        end
        checks++;
        if (nb != 39)  begin failures++; $display("FAIL divmem_busy: got %0d want 39", nb); end
        checks++;
        if (nall != 5) begin failures++; $display("FAIL divmem_allstall: got %0d want 5", nall); end
        checks++;
        if (nse != 38) begin failures++; $display("FAIL divmem_stallE: got %0d want 38", nse); end
    endtask

    task automatic test_pending_flush();
        int nfl;
        nfl = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            i_stall = 1; flush_exceptionM = (c == 0);
            @(negedge clk);
            nfl += int'(fD_a | fE_a | fM_a | fW_a | fD_b | fE_b | fM_b | fW_b);
            tick();
        end
        checks++;
        if (nfl != 0) begin failures++; $display("FAIL pend_hold: got %0d flush cycles want 0", nfl); end
        i_stall = 0;
        @(negedge clk);
        checks++;
        if ({fD_a, fE_a, fM_a, fW_a, sF_a} !== 5'b11110 || {fD_b, fE_b, fM_b, fW_b} !== 4'b1111) begin
            failures++;
            $display("FAIL pend_release: got %b/%b want 11110/1111",
                     {fD_a, fE_a, fM_a, fW_a, sF_a}, {fD_b, fE_b, fM_b, fW_b});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({fD_a, fE_a, fM_a, fW_a} !== 4'b0000) begin
            failures++; $display("FAIL pend_clear: got %b want 0000", {fD_a, fE_a, fM_a, fW_a});
        end
        tick();
    endtask

    task automatic test_branch_fwd();
        do_reset();
        branchD = 1; rsD = 5'd5; rtD = 5'd6; regwriteW = 1; writeregW = 5'd5;
        @(negedge clk);
        checks++;
        if ({faD_a, sD_a} !== 3'b010) begin
            failures++; $display("FAIL br_w2d_on: got %b want 010", {faD_a, sD_a});
        end
        checks++;
        if ({faD_b, sD_b, fE_b} !== 4'b0011) begin
            failures++; $display("FAIL br_w2d_off: got %b want 0011", {faD_b, sD_b, fE_b});
        end
        tick();
        regwriteW = 0;
        regwriteM = 1; writeregM = 5'd6;
        @(negedge clk);
        checks++;
        if ({fbD_a, fbD_b, sD_a, sD_b} !== 6'b101000) begin
            failures++; $display("FAIL br_fwd_m: got %b want 101000", {fbD_a, fbD_b, sD_a, sD_b});
        end
        tick();
        idle_inputs();
        regjumpD = 1; rsD = 5'd9; regwriteE = 1; writeregE = 5'd9;
        @(negedge clk);
        checks++;
        if ({sF_a, sD_a, fE_a} !== 3'b111) begin
            failures++; $display("FAIL jr_stall: got %b want 111", {sF_a, sD_a, fE_a});
        end
        tick();
        branchD = 1; rsD = 5'd0; rtD = 5'd0; writeregE = 5'd0; regwriteW = 1; writeregW = 5'd0;
        @(negedge clk);
        checks++;
        if ({sD_b, faD_b, sD_a} !== 4'b0000) begin
            failures++; $display("FAIL br_reg0: got %b want 0000", {sD_b, faD_b, sD_a});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int nev;
        do_reset();
        div_startE = 1;
        for (int c = 0; c < 5; c++) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy_a); end
        tick();
        div_startE = 0;
        resetn = 1'b1;
        nev = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nev += int'(busy_a | sD_a);
            tick();
        end
        checks++;
        if (nev != 0) begin failures++; $display("FAIL rst_abandon: got %0d busy cycles want 0", nev); end
        div_startE = 1;
        tick();
        i_stall = 1; flush_exceptionM = 1;
        tick();
        flush_exceptionM = 0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (oa !== '0) begin failures++; $display("FAIL rst_pend_out: got %h want 0", oa); end
        tick();
        idle_inputs();
        resetn = 1'b1;
        nev = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nev += int'(fD_a | fE_a | fM_a | fW_a | busy_a | fD_b | busy_b);
            tick();
        end
        checks++;
        if (nev != 0) begin failures++; $display("FAIL rst_no_flush: got %0d events want 0", nev); end
    endtask

    task automatic test_random();
        outs_t ea, eb;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD   = ($urandom_range(0, 3) == 0);
            regjumpD  = ($urandom_range(0, 5) == 0);
            regwriteE = $urandom_range(0, 1) == 1;
            memtoregE = ($urandom_range(0, 3) == 0);
            regwriteM = $urandom_range(0, 1) == 1;
            memtoregM = ($urandom_range(0, 3) == 0);
            regwriteW = $urandom_range(0, 1) == 1;
            div_startE       = ($urandom_range(0, 5) == 0);
            flush_exceptionM = ($urandom_range(0, 15) == 0);
            i_stall          = ($urandom_range(0, 7) == 0);
            d_stall          = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            ea = model(0);
            eb = model(1);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL rand_a[%0d]: got %h want %h", c, oa, ea); end
            checks++;
            if (ob !== eb) begin failures++; $display("FAIL rand_b[%0d]: got %h want %h", c, ob, eb); end
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_lw_hazard();
        test_div();
        test_div_memstall();
        test_pending_flush();
        test_branch_fwd();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W). Replaces the purely combinational hazard unit.
- Adds several behaviours to that unit:
  - an internal multi-cycle divider busy counter;
  - a global stall from the instruction and data SRAM buses;
  - a pending-flush register, so an exception raised during a bus stall is not lost;
  - optional W-to-D forwarding for branch compare.
- Sits beside the datapath and drives every stage's stall, flush and forward selects.

Parameters:
- REG_AW, 5: register address width. Register 0 is never forwarded and never hazards.
- DIV_CYCLES, 34: total E-stage occupancy of a div/divu, in cycles, counted from the start cycle. Must be at least 2.
- FWD_W2D, 1: 1 enables forwarding from W into D for branch/jr compare. 0 makes D stall on a pending W write instead.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD, regjumpD  in  1  D holds a branch / jr-jalr
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
- regwriteE, memtoregE  in  1  E writes a GPR / E is a load
- div_startE  in  1  E holds a div/divu
- writeregM  in  REG_AW  M-stage destination
- regwriteM, memtoregM  in  1  M writes a GPR / M is a load
- flush_exceptionM  in  1  exception or eret committed in M
- writeregW  in  REG_AW  W-stage destination
- regwriteW  in  1  W writes a GPR
- i_stall, d_stall  in  1  instruction / data SRAM not ready
- forwardaD, forwardbD  out  2  D-stage forward select: 00 regfile, 01 W, 10 M
- forwardaE, forwardbE  out  2  E-stage forward select: 00 regfile, 01 W, 10 M
- stallF, stallD, stallE, stallM, stallW  out  1  per-stage hold
- flushD, flushE, flushM, flushW  out  1  per-stage bubble insert
- div_busy  out  1  divider occupying E

Behaviour:
- Reset (resetn=0, asynchronous): div counter=0, flush_pend=0, div_busy=0. All stall, flush and forward outputs read 0 while in reset.
- Forwarding, combinational:
  - E stage: M has priority over W. A source of 0 gives 00.
  - D stage: M only when FWD_W2D=0; M then W when FWD_W2D=1.
- Hazards, combinational:
  - lwstall = memtoregE and (rtE == rsD or rtE == rtD), with the matching register non-zero.
  - brstall = branchD and ((regwriteE and writeregE matches rsD/rtD) or (memtoregM and writeregM matches rsD/rtD)). With FWD_W2D=0, a regwriteW match is also included.
  - jrstall: same as brstall but uses rsD only and is qualified by regjumpD.
  - All matches exclude register 0.
- Divider counter:
  - When idle, div_startE=1 and no flush: load DIV_CYCLES-1. div_busy=1 from that cycle on.
  - Decrement each cycle while non-zero and mem_stall=0. The counter freezes during a bus stall.
  - div_stall = (div_startE and counter≠1) or (counter>1), so E is released in the final cycle.
  - flush_exceptionM clears the counter next edge, since the divide is younger than the excepting instruction.
- mem_stall = i_stall or d_stall.
  - Forces stallF=stallD=stallE=stallM=stallW=1.
  - Suppresses all flush outputs and suppresses lwstall/brstall bubble insertion.
- Pending flush:
  - flush_pend is set when flush_exceptionM=1 and mem_stall=1.
  - It is cleared on the first cycle with mem_stall=0, in which flush_req = flush_exceptionM or flush_pend.
- Flush:
  - flushD=flushM=flushW = flush_req and not mem_stall.
  - flushE = that value, or (pipeline stall and not div_stall and not mem_stall).
- Stall when mem_stall=0:
  - stallD = lwstall or brstall or jrstall or div_stall. stallE = div_stall.
  - stallF = stallD and not flush_req. stallM = stallW = 0.
- Simultaneous events:
  - flush_req beats every hazard: stallF=0 so F loads the vector.
  - div_startE together with a flush does not start the counter.
  - Reset mid-divide abandons the divide.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds four PERF_W-wide (parameter, default 32) saturating counters, each incrementing once per cycle its condition is the dominant stall cause: perf_lw, perf_br (branch+jr), perf_div, perf_mem. Each is exposed as an output port. All are reset by resetn.
- When undefined, the counters and ports are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - REG_AW default;
  - DIV_CYCLES default.
- One natural sub-module, div_busy_cnt: the counter, start, freeze, clear and div_stall logic.

Test Plan:
- lw $3 in E, add rs=$3 in D → stallF=stallD=flushE=1 for 1 cycle. Next cycle forwardaE=01.
- div in E, DIV_CYCLES=34 → div_busy=1 for 34 cycles, stallD=stallE=1 for 33, flushE=0 throughout.
- div counting, d_stall held 5 cycles → counter frozen, div_busy total 39 cycles, all stalls=1 during the bus stall.
- flush_exceptionM=1 while i_stall=1 for 3 cycles → flushes stay 0, flush_pend=1. Once i_stall drops: flushD/E/M/W=1 for exactly 1 cycle, then flush_pend=0.
- beq rs=$5, W writes $5, FWD_W2D=1 → forwardaD=01, no stall. With FWD_W2D=0 → stallD=1 for 1 cycle.
- resetn low mid-divide with flush_pend=1 → div_busy=0 and flush_pend=0 immediately. No flush pulse after release.
